// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives a 1-bit ALU slice LSB-first over WIDTH cycles
// and assembles the result and final carry behind a start/busy/done handshake.

module ALU (
  input  logic [2:0] M,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       out,
  output logic       next
);
  // M: 000 add, 001 and, 010 or, 011 xor, 100 xnor; other codes give 0
  always_comb begin
    out  = 1'b0;
    next = 1'b0;
    case (M)
      3'b000: begin
        out  = a ^ b ^ c;
        next = (a & b) | (c & (a ^ b));
      end
      3'b001:  out = a & b;
      3'b010:  out = a | b;
      3'b011:  out = a ^ b;
      3'b100:  out = ~(a ^ b);
      default: out = 1'b0;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [2:0]       OP_ADD   = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, result_q;
  logic [2:0]       op_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  logic slice_out, slice_next;
  logic bit_d, carry_d;

  ALU u_slice (
    .M    (op_q),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c    (carry_q),
    .out  (slice_out),
    .next (slice_next)
  );

  // Reserved ops insert zeros regardless of what the slice produces.
  always_comb begin
    bit_d   = (op_q > 3'b100) ? 1'b0 : slice_out;
    carry_d = (op_q == OP_ADD) ? slice_next : 1'b0;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // the shift registers are reset too, which is cheap at this width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            op_q     <= op;
            carry_q  <= (op == OP_ADD) ? cin : 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          result_q <= {bit_d, result_q[WIDTH-1:1]};
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: vector table plus hand-written
// sequences for back-to-back, start-while-busy, mid-op reset and reserved ops.

module tb_alu_serial_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;

  alu_serial_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] res;
    logic             co;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [WIDTH:0] exp_q[$];
  int done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout, result}.
  always @(negedge clk) begin
    if (done) begin
      logic [WIDTH:0] e;
      done_cnt++;
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e[WIDTH-1:0]));
        check("cout", 32'(cout), 32'(e[WIDTH]));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 40) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Drives one request at the first idle negedge; returns at the negedge after E0.
  task automatic run_op(input vec_t v, input bit push);
    wait_idle();
    op = v.op; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    if (push) exp_q.push_back({v.co, v.res});
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Counts busy cycles (including the accept cycle) and the E0-to-done distance.
  task automatic measure(output int nbusy, output int ddelta);
    int c0;
    c0 = cyc;
    nbusy = 1;
    ddelta = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ddelta = cyc - c0;
      if (busy) nbusy++;
      else break;
    end
  endtask

  vec_t vecs[4];
  vec_t v;
  int nbusy, ddelta, dc0;

  initial begin
    vecs[0] = '{op: 3'b001, a: 8'hF0, b: 8'h3C, cin: 1'b1, res: 8'h30, co: 1'b0};
    vecs[1] = '{op: 3'b010, a: 8'hF0, b: 8'h0F, cin: 1'b1, res: 8'hFF, co: 1'b0};
    vecs[2] = '{op: 3'b011, a: 8'hAA, b: 8'hFF, cin: 1'b1, res: 8'h55, co: 1'b0};
    vecs[3] = '{op: 3'b100, a: 8'hAA, b: 8'hFF, cin: 1'b1, res: 8'hAA, co: 1'b0};

    // Reset for two cycles
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with latency and busy length
    v = '{op: 3'b000, a: 8'h5A, b: 8'h3C, cin: 1'b0, res: 8'h96, co: 1'b0};
    run_op(v, 1'b1);
    measure(nbusy, ddelta);
    check("add_busy_cycles", 32'(nbusy), 32'd9);
    check("add_done_latency", 32'(ddelta), 32'd8);

    // Carry chain
    v = '{op: 3'b000, a: 8'hFF, b: 8'h01, cin: 1'b1, res: 8'h01, co: 1'b1};
    run_op(v, 1'b1);
    wait_done();
    v = '{op: 3'b000, a: 8'h00, b: 8'h00, cin: 1'b1, res: 8'h01, co: 1'b0};
    run_op(v, 1'b1);
    wait_done();

    // Logic ops back-to-back at the earliest accepted edge
    wait_idle();
    done_cyc_q.delete();
    for (int i = 0; i < 4; i++) run_op(vecs[i], 1'b1);
    wait_done();
    @(negedge clk);
    check("b2b_done_count", 32'(done_cyc_q.size()), 32'd4);
    for (int i = 1; i < done_cyc_q.size(); i++)
      check("b2b_spacing", 32'(done_cyc_q[i] - done_cyc_q[i-1]), 32'(WIDTH + 2));

    // Start while busy: at E3 and in the DONE cycle
    dc0 = done_cnt;
    v = '{op: 3'b000, a: 8'h01, b: 8'h01, cin: 1'b0, res: 8'h02, co: 1'b0};
    run_op(v, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; a = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("busy_ign_done_count", 32'(done_cnt - dc0), 32'd1);
    check("busy_ign_result", 32'(result), 32'h02);
    check("busy_ign_idle", 32'(busy), 32'd0);

    // Reset mid-operation at E4
    dc0 = done_cnt;
    v = '{op: 3'b000, a: 8'h7F, b: 8'h01, cin: 1'b0, res: 8'h80, co: 1'b0};
    run_op(v, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'h00);
    check("midrst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    run_op(v, 1'b1);
    wait_done();

    // Reserved op
    v = '{op: 3'b110, a: 8'hFF, b: 8'hFF, cin: 1'b1, res: 8'h00, co: 1'b0};
    run_op(v, 1'b1);
    measure(nbusy, ddelta);
    check("rsv_busy_cycles", 32'(nbusy), 32'd9);
    check("rsv_done_latency", 32'(ddelta), 32'd8);

    repeat (3) @(negedge clk);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
